audio_mix_scheduler: RTL and testbench

Sits between up to NUM_SRC audio sample producers (CPU FIFO, synth voices, DMA streams) and the i2s_output block. It shares the single stereo I2S output among the producers. On each consumption strobe from i2s_output, it polls every enabled source in a fixed round-robin order and pulls one stereo sample from each. It sums the samples with headroom, applies a master attenuation shift, then saturates and presents the next sample pair.

---
 rtl/audio_mix_scheduler.sv | 149 ++++++++++++++
 tb/tb_audio_mix_scheduler.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_scheduler.sv
// Round-robin stereo mixer feeding i2s_output: one source polled per cycle, summed with headroom, shifted, saturated.
// Optional per-source gain enabled by defining MIX_VOLUME_EN (adds src_volume, 128 = unity).
module audio_mix_scheduler #(
    parameter int NUM_SRC  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_enable,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*SAMPLE_W-1:0]  src_left,
    input  logic [NUM_SRC*SAMPLE_W-1:0]  src_right,
`ifdef MIX_VOLUME_EN
    input  logic [NUM_SRC*8-1:0]         src_volume,
`endif
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [1:0]                   master_shift,
    input  logic                         sample_strobe,
    output logic [SAMPLE_W-1:0]          sample_left,
    output logic [SAMPLE_W-1:0]          sample_right,
    output logic                         busy,
    output logic [15:0]                  underrun_count,
    output logic                         mix_overrun
);

`ifdef MIX_VOLUME_EN
    localparam int ACC_W = SAMPLE_W + 4;
`else
    localparam int ACC_W = SAMPLE_W + 3;
`endif
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));

    typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

    state_t                     state, state_next;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc_left, acc_right;
    logic signed [ACC_W-1:0]    add_left, add_right;
    logic signed [ACC_W-1:0]    shifted_left, shifted_right;
    logic signed [SAMPLE_W-1:0] cur_left, cur_right;
    logic                       slot_take, slot_underrun;

    function automatic logic [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[SAMPLE_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[SAMPLE_W-1:0];
        else
            return v[SAMPLE_W-1:0];
    endfunction

    // Current slot decode: which source is being polled and what it contributes.
    always_comb begin
        cur_left      = src_left[idx*SAMPLE_W +: SAMPLE_W];
        cur_right     = src_right[idx*SAMPLE_W +: SAMPLE_W];
        slot_take     = (state == COLLECT) && src_enable[idx] && src_valid[idx];
        slot_underrun = (state == COLLECT) && src_enable[idx] && !src_valid[idx];
    end

`ifdef MIX_VOLUME_EN
    logic [7:0]                 cur_volume;
    logic signed [SAMPLE_W+8:0] prod_left, prod_right;

    always_comb begin
        cur_volume = src_volume[idx*8 +: 8];
        prod_left  = cur_left * $signed({1'b0, cur_volume});
        prod_right = cur_right * $signed({1'b0, cur_volume});
        add_left   = ACC_W'(prod_left >>> 7);
        add_right  = ACC_W'(prod_right >>> 7);
    end
`else
    always_comb begin
        add_left  = ACC_W'(cur_left);
        add_right = ACC_W'(cur_right);
    end
`endif

    always_comb begin
        shifted_left  = acc_left >>> master_shift;
        shifted_right = acc_right >>> master_shift;
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_strobe) state_next = COLLECT;
            COLLECT: if (idx == LAST_IDX) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_ready = '0;
        if (slot_take)
            src_ready[idx] = 1'b1;
        busy = (state != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx            <= '0;
            acc_left       <= '0;
            acc_right      <= '0;
            sample_left    <= '0;
            sample_right   <= '0;
            underrun_count <= '0;
            mix_overrun    <= 1'b0;
        end else begin
            // A strobe that lands mid-mix is dropped; only the sticky flag records it.
            if (sample_strobe && state != IDLE)
                mix_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        acc_left  <= '0;
                        acc_right <= '0;
                        idx       <= '0;
                    end
                end
                COLLECT: begin
                    if (slot_take) begin
                        acc_left  <= acc_left + add_left;
                        acc_right <= acc_right + add_right;
                    end
                    if (slot_underrun && underrun_count != 16'hFFFF)
                        underrun_count <= underrun_count + 16'd1;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                FINISH: begin
                    sample_left  <= saturate(shifted_left);
                    sample_right <= saturate(shifted_right);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Directed bench for audio_mix_scheduler: vector table of whole mixes plus overrun, reset and underrun sequences.
module tb_audio_mix_scheduler;

    localparam int N = 4;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   src_enable;
    logic [N-1:0]   src_valid;
    logic [N*W-1:0] src_left;
    logic [N*W-1:0] src_right;
    logic [N-1:0]   src_ready;
    logic [1:0]     master_shift;
    logic           sample_strobe;
    logic [W-1:0]   sample_left;
    logic [W-1:0]   sample_right;
    logic           busy;
    logic [15:0]    underrun_count;
    logic           mix_overrun;
`ifdef MIX_VOLUME_EN
    logic [N*8-1:0] src_volume;
`endif

    int compared   = 0;
    int mismatched = 0;
    int exp_underrun = 0;

    always #4 clock = ~clock;

    audio_mix_scheduler #(.NUM_SRC(N), .SAMPLE_W(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .src_enable     (src_enable),
        .src_valid      (src_valid),
        .src_left       (src_left),
        .src_right      (src_right),
`ifdef MIX_VOLUME_EN
        .src_volume     (src_volume),
`endif
        .src_ready      (src_ready),
        .master_shift   (master_shift),
        .sample_strobe  (sample_strobe),
        .sample_left    (sample_left),
        .sample_right   (sample_right),
        .busy           (busy),
        .underrun_count (underrun_count),
        .mix_overrun    (mix_overrun)
    );

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  val;
        logic [63:0] l;
        logic [63:0] r;
        int          shift;
        int          exp_l;
        int          exp_r;
        int          exp_un;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] val, input logic [63:0] l,
                                input logic [63:0] r, input int shift, input int el, input int er,
                                input int eu);
        vec_t v;
        v.en = en; v.val = val; v.l = l; v.r = r; v.shift = shift;
        v.exp_l = el; v.exp_r = er; v.exp_un = eu;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        src_enable   = v.en;
        src_valid    = v.val;
        src_left     = v.l;
        src_right    = v.r;
        master_shift = 2'(v.shift);
    endtask

    // Strobe in cycle T, check each slot's ready pulse, FINISH busy, then the settled outputs.
    task automatic run_mix(input string tag, input logic [3:0] take);
        @(negedge clock);
        sample_strobe = 1'b1;
        @(negedge clock);
        sample_strobe = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k > 0) @(negedge clock);
            chk({tag, " src_ready"}, int'(src_ready), take[k] ? (1 << k) : 0);
        end
        @(negedge clock);
        chk({tag, " finish busy"}, int'(busy), 1);
        chk({tag, " finish ready"}, int'(src_ready), 0);
        @(negedge clock);
        chk({tag, " idle busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        sample_strobe = 1'b0;
        src_enable    = '0;
        src_valid     = '0;
        src_left      = '0;
        src_right     = '0;
        master_shift  = '0;
`ifdef MIX_VOLUME_EN
        src_volume    = {4{8'd128}};
`endif

        vecs[0] = mk(4'hF, 4'hF, pack4(1000, 2000, -500, 300), pack4(-1, -2, -3, -4), 0, 2800, -10, 0);
        vecs[1] = mk(4'hF, 4'hF, pack4(20000, 20000, 20000, 20000),
                     pack4(-20000, -20000, -20000, -20000), 0, 32767, -32768, 0);
        vecs[2] = mk(4'hF, 4'hF, pack4(20000, 20000, 20000, 20000),
                     pack4(-20000, -20000, -20000, -20000), 2, 20000, -20000, 0);
        vecs[3] = mk(4'b0101, 4'b1001, pack4(100, 7000, 9000, 5000), pack4(-50, 1, 2, 3), 0, 100, -50, 1);
        vecs[4] = mk(4'b0000, 4'hF, pack4(1, 2, 3, 4), pack4(1, 2, 3, 4), 0, 0, 0, 0);
        vecs[5] = mk(4'b0001, 4'b0001, pack4(-7, 5, 5, 5), pack4(9, 5, 5, 5), 3, -1, 1, 0);
        vecs[6] = mk(4'hF, 4'hF, pack4(32767, 32767, -32768, 1), pack4(-32768, -32768, 0, 0), 1,
                     16383, -32768, 0);
        vecs[7] = mk(4'hF, 4'b0110, pack4(9, -3000, -1000, 9), pack4(9, 4000, 8000, 9), 2, -1000, 3000, 2);

        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        chk("reset sample_left", int'(sample_left), 0);
        chk("reset sample_right", int'(sample_right), 0);
        chk("reset src_ready", int'(src_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset underrun_count", int'(underrun_count), 0);
        chk("reset mix_overrun", int'(mix_overrun), 0);

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i]);
            run_mix($sformatf("vec%0d", i), vecs[i].en & vecs[i].val);
            exp_underrun += vecs[i].exp_un;
            chk($sformatf("vec%0d sample_left", i), int'($signed(sample_left)), vecs[i].exp_l);
            chk($sformatf("vec%0d sample_right", i), int'($signed(sample_right)), vecs[i].exp_r);
            chk($sformatf("vec%0d underrun_count", i), int'(underrun_count), exp_underrun);
        end
        chk("no overrun yet", int'(mix_overrun), 0);

        // Second strobe two cycles into a mix must not restart it.
        apply(vecs[0]);
        @(negedge clock);
        sample_strobe = 1'b1;
        @(negedge clock);
        sample_strobe = 1'b0;
        @(negedge clock);
        sample_strobe = 1'b1;
        @(negedge clock);
        sample_strobe = 1'b0;
        repeat (3) @(negedge clock);
        chk("overrun busy done", int'(busy), 0);
        chk("overrun flag", int'(mix_overrun), 1);
        chk("overrun sample_left", int'($signed(sample_left)), 2800);
        chk("overrun sample_right", int'($signed(sample_right)), -10);
        repeat (2) @(negedge clock);
        chk("overrun sticky", int'(mix_overrun), 1);

        // Reset asserted mid-mix: ready drops at that edge, outputs and flags clear.
        apply(vecs[0]);
        @(negedge clock);
        sample_strobe = 1'b1;
        @(negedge clock);
        sample_strobe = 1'b0;
        @(negedge clock);
        chk("pre-reset src_ready", int'(src_ready), 2);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset src_ready", int'(src_ready), 0);
        chk("midreset busy", int'(busy), 0);
        chk("midreset sample_left", int'(sample_left), 0);
        chk("midreset overrun", int'(mix_overrun), 0);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("postreset busy", int'(busy), 0);
        chk("postreset sample_left", int'(sample_left), 0);

        // Three frames with src2 underrunning and src1 disabled.
        apply(vecs[3]);
        for (int f = 0; f < 3; f++)
            run_mix($sformatf("under%0d", f), 4'b0001);
        chk("underrun 3 frames", int'(underrun_count), 3);
        chk("underrun sample_left", int'($signed(sample_left)), 100);

`ifdef MIX_VOLUME_EN
        do_reset();
        apply(mk(4'b0001, 4'b0001, pack4(1000, 0, 0, 0), pack4(-1000, 0, 0, 0), 0, 0, 0, 0));
        src_volume = {8'd128, 8'd128, 8'd128, 8'd64};
        run_mix("vol64", 4'b0001);
        chk("vol64 sample_left", int'($signed(sample_left)), 500);
        chk("vol64 sample_right", int'($signed(sample_right)), -500);
        apply(mk(4'b0001, 4'b0001, pack4(32767, 0, 0, 0), pack4(-32768, 0, 0, 0), 0, 0, 0, 0));
        src_volume = {8'd128, 8'd128, 8'd128, 8'd255};
        run_mix("vol255", 4'b0001);
        chk("vol255 sample_left", int'($signed(sample_left)), 32767);
        chk("vol255 sample_right", int'($signed(sample_right)), -32768);
        src_volume = {4{8'd128}};
`else
        do_reset();
        chk("final reset underrun", int'(underrun_count), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
